// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART for the peripheral bus.
// TXD at 0x40000018, RXD at 0x4000001C, CON (enables/status flags) at 0x40000020.
// irqout is meant to be ORed with the timer IRQ upstream; rdata with the other peripherals.
module uart_peripheral #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Bus decodes
    logic wr_txd, wr_con, rd_rxd;
    assign wr_txd = wr && (addr == ADDR_TXD);
    assign wr_con = wr && (addr == ADDR_CON);
    assign rd_rxd = rd && (addr == ADDR_RXD);

    // Upper write-data bits carry no register content
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata[31:8]};

    // Transmitter state
    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic          tx_busy;

    // Receiver state
    logic          rx_sync1, rx_sync2;
    state_t        rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;

    // Control enables
    logic tx_irq_en, rx_irq_en;

    // tx_busy spans from the accepting TXD write until the stop bit has been sent
    assign tx_busy = (tx_state != IDLE);

    // Interrupt enables, written directly from CON[1:0]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
        end else if (wr_con) begin
            tx_irq_en <= wdata[0];
            rx_irq_en <= wdata[1];
        end
    end

    // TX FSM: start bit, 8 data bits LSB first, stop bit; uart_tx is registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            tx_done  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            // W1C first so a hardware set later in this block wins
            if (wr_con && wdata[2])
                tx_done <= 1'b0;
            case (tx_state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (wr_txd) begin
                        tx_byte  <= wdata[7:0];
                        tx_cnt   <= '0;
                        tx_state <= START;
                        uart_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= DATA;
                        uart_tx  <= tx_byte[0];
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_idx  <= tx_idx + 3'd1;
                            uart_tx <= tx_byte[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= IDLE;
                        tx_done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_state <= IDLE;
                    uart_tx  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser; resets to the idle-high line level so no false start follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
        end
    end

    // RX FSM: confirm start at half a bit, then sample every bit centre including stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Clears first so a same-edge hardware set takes priority
            if (rd_rxd)
                rx_ready <= 1'b0;
            if (wr_con && wdata[5])
                frame_err <= 1'b0;
            if (wr_con && wdata[6])
                overrun <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (!rx_sync2) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        // A line back high at mid start bit was only a glitch
                        rx_state <= rx_sync2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        if (rx_idx == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_idx <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (rx_sync2) begin
                            rx_byte  <= rx_shift;
                            rx_ready <= 1'b1;
                            if (rx_ready)
                                overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign irqout = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready);

    // Combinational read mux; zero when idle or unmapped so the upstream OR works
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (addr)
                ADDR_TXD: rdata = {24'h0, tx_byte};
                ADDR_RXD: rdata = {24'h0, rx_byte};
                ADDR_CON: rdata = {25'h0, overrun, frame_err, tx_busy, rx_ready,
                                   tx_done, rx_irq_en, tx_irq_en};
                default:  rdata = 32'h0;
            endcase
        end
    end

endmodule
